// File: rtl/mips_pkg.sv
// Shared MIPS encoder definitions: op classes, opcodes, request field bundle and FSM states.
package mips_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned CLASS_W = 4;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned TGT_W   = 26;

   typedef enum logic [CLASS_W-1:0] {
      CL_R_TYPE = 4'd0,
      CL_ADDI   = 4'd1,
      CL_SLTIU  = 4'd2,
      CL_BEQ    = 4'd3,
      CL_LUI    = 4'd4,
      CL_ORI    = 4'd5,
      CL_BNE    = 4'd6,
      CL_LW     = 4'd7,
      CL_SW     = 4'd8,
      CL_BLEZ   = 4'd9,
      CL_BGTZ   = 4'd10,
      CL_JR     = 4'd11,
      CL_J      = 4'd12,
      CL_JAL    = 4'd13,
      CL_LI     = 4'd14,
      CL_RSVD   = 4'd15
   } op_class_e;

   localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
   localparam logic [OP_W-1:0] OP_J       = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;
   localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE     = 6'b000101;
   localparam logic [OP_W-1:0] OP_BLEZ    = 6'b000110;
   localparam logic [OP_W-1:0] OP_BGTZ    = 6'b000111;
   localparam logic [OP_W-1:0] OP_ADDI    = 6'b001000;
   localparam logic [OP_W-1:0] OP_SLTIU   = 6'b001011;
   localparam logic [OP_W-1:0] OP_ORI     = 6'b001101;
   localparam logic [OP_W-1:0] OP_LUI     = 6'b001111;
   localparam logic [OP_W-1:0] OP_LW      = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW      = 6'b101011;
   localparam logic [OP_W-1:0] FUNCT_JR   = 6'b001000;

   typedef struct packed {
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] shamt;
      logic [OP_W-1:0]  funct;
      logic [XLEN-1:0]  imm;
      logic [TGT_W-1:0] target;
   } op_fields_t;

   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      FULL      = 2'd1,
      FULL_PEND = 2'd2
   } enc_state_e;

   function automatic logic [XLEN-1:0] itype(input logic [OP_W-1:0]  op,
                                             input logic [REG_W-1:0] rs,
                                             input logic [REG_W-1:0] rt,
                                             input logic [IMM_W-1:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // LI needs LUI+ORI only when both halves of the constant are non-zero.
   function automatic logic li_needs_pair(input logic [XLEN-1:0] imm);
      return (|imm[XLEN-1:IMM_W]) && (|imm[IMM_W-1:0]);
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of one request into a single 32-bit MIPS word.
module instr_field_pack
   import mips_pkg::*;
(
   input  logic [CLASS_W-1:0] class_i,
   input  op_fields_t         fields_i,
   input  logic               li_lo_i,
   output logic [XLEN-1:0]    word_c_o
);

   logic [IMM_W-1:0] imm_lo;
   logic [IMM_W-1:0] imm_hi;

   assign imm_lo = fields_i.imm[IMM_W-1:0];
   assign imm_hi = fields_i.imm[XLEN-1:IMM_W];

   always_comb begin : pack
      word_c_o = '0;
      case (class_i)
         CL_R_TYPE: word_c_o = {OP_SPECIAL, fields_i.rs, fields_i.rt, fields_i.rd,
                                fields_i.shamt, fields_i.funct};
         CL_JR:     word_c_o = {OP_SPECIAL, fields_i.rs, 5'd0, 5'd0, 5'd0, FUNCT_JR};
         CL_ADDI:   word_c_o = itype(OP_ADDI,  fields_i.rs, fields_i.rt, imm_lo);
         CL_SLTIU:  word_c_o = itype(OP_SLTIU, fields_i.rs, fields_i.rt, imm_lo);
         CL_BEQ:    word_c_o = itype(OP_BEQ,   fields_i.rs, fields_i.rt, imm_lo);
         CL_BNE:    word_c_o = itype(OP_BNE,   fields_i.rs, fields_i.rt, imm_lo);
         CL_ORI:    word_c_o = itype(OP_ORI,   fields_i.rs, fields_i.rt, imm_lo);
         CL_LW:     word_c_o = itype(OP_LW,    fields_i.rs, fields_i.rt, imm_lo);
         CL_SW:     word_c_o = itype(OP_SW,    fields_i.rs, fields_i.rt, imm_lo);
         CL_LUI:    word_c_o = itype(OP_LUI,   5'd0,        fields_i.rt, imm_lo);
         CL_BLEZ:   word_c_o = itype(OP_BLEZ,  fields_i.rs, 5'd0,        imm_lo);
         CL_BGTZ:   word_c_o = itype(OP_BGTZ,  fields_i.rs, 5'd0,        imm_lo);
         CL_J:      word_c_o = {OP_J,   fields_i.target};
         CL_JAL:    word_c_o = {OP_JAL, fields_i.target};
         // li_lo_i selects the trailing ORI of a two-word expansion.
         CL_LI: begin
            if (li_lo_i) begin
               word_c_o = itype(OP_ORI, fields_i.rt, fields_i.rt, imm_lo);
            end else if (imm_hi == '0) begin
               word_c_o = itype(OP_ORI, 5'd0, fields_i.rt, imm_lo);
            end else begin
               word_c_o = itype(OP_LUI, 5'd0, fields_i.rt, imm_hi);
            end
         end
         default:   word_c_o = '0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: request handshake, one-word output register with LI
// expansion slot, and an auto-incrementing write-address counter.
module instr_encoder
   import mips_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               op_valid_i,
   output logic               op_ready_o,
   input  logic [CLASS_W-1:0] op_class_i,
   input  logic [REG_W-1:0]   rs_i,
   input  logic [REG_W-1:0]   rt_i,
   input  logic [REG_W-1:0]   rd_i,
   input  logic [REG_W-1:0]   shamt_i,
   input  logic [OP_W-1:0]    funct_i,
   input  logic [XLEN-1:0]    imm_i,
   input  logic [TGT_W-1:0]   target_i,
   input  logic               addr_load_i,
   input  logic [XLEN-1:0]    addr_base_i,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic [XLEN-1:0]    instr_o,
   output logic [XLEN-1:0]    instr_addr_o,
   output logic               err_o
);

   localparam logic [XLEN-1:0] ADDR_STEP  = XLEN'(4);
   localparam logic [XLEN-1:0] ADDR_ALIGN = ~XLEN'(3);

   enc_state_e      state_q, state_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] word_q,  word_d;
   logic [XLEN-1:0] pend_q,  pend_d;
   logic [XLEN-1:0] addr_q,  addr_d;
   logic            err_q,   err_d;

   op_fields_t      fields;
   logic [XLEN-1:0] first_word_c;
   logic [XLEN-1:0] pend_word_c;
   logic            accept_c;
   logic            xfer_c;
   logic            rsvd_c;
   logic            li_pair_c;

   assign fields = '{rs: rs_i, rt: rt_i, rd: rd_i, shamt: shamt_i,
                     funct: funct_i, imm: imm_i, target: target_i};

   instr_field_pack u_pack_first (
      .class_i  (op_class_i),
      .fields_i (fields),
      .li_lo_i  (1'b0),
      .word_c_o (first_word_c)
   );

   // Second instance precomputes the trailing ORI so it can be parked in pend_q.
   instr_field_pack u_pack_pend (
      .class_i  (op_class_i),
      .fields_i (fields),
      .li_lo_i  (1'b1),
      .word_c_o (pend_word_c)
   );

   always_comb begin : ready_decode
      op_ready_o = 1'b0;
      case (state_q)
         EMPTY:   op_ready_o = 1'b1;
         FULL:    op_ready_o = instr_ready_i;
         default: op_ready_o = 1'b0;
      endcase
   end

   assign accept_c  = op_valid_i & op_ready_o;
   assign xfer_c    = valid_q & instr_ready_i;
   assign rsvd_c    = (op_class_i == CL_RSVD);
   assign li_pair_c = (op_class_i == CL_LI) && li_needs_pair(imm_i);

   always_comb begin : next_state
      state_d = state_q;
      valid_d = valid_q;
      word_d  = word_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      err_d   = 1'b0;

      if (xfer_c) begin
         addr_d = addr_q + ADDR_STEP;
      end

      case (state_q)
         EMPTY: begin
            if (!accept_c && addr_load_i) begin
               addr_d = addr_base_i & ADDR_ALIGN;
            end
         end
         FULL: begin
            if (xfer_c) begin
               state_d = EMPTY;
               valid_d = 1'b0;
            end
         end
         FULL_PEND: begin
            if (xfer_c) begin
               state_d = FULL;
               word_d  = pend_q;
            end
         end
         default: begin
            state_d = EMPTY;
            valid_d = 1'b0;
         end
      endcase

      // An accept only happens in EMPTY or alongside a transfer out of FULL.
      if (accept_c) begin
         if (rsvd_c) begin
            state_d = EMPTY;
            valid_d = 1'b0;
            err_d   = 1'b1;
         end else begin
            state_d = li_pair_c ? FULL_PEND : FULL;
            valid_d = 1'b1;
            word_d  = first_word_c;
            pend_d  = pend_word_c;
         end
      end
   end

   always_ff @(posedge clk_i) begin : regs
      if (rst_i) begin
         state_q <= EMPTY;
         valid_q <= 1'b0;
         word_q  <= '0;
         pend_q  <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         word_q  <= word_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   assign instr_valid_o = valid_q;
   assign instr_o       = word_q;
   assign instr_addr_o  = addr_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected {word, addr},
// a negedge monitor pops and compares on every output transfer.
module tb_instr_encoder;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        op_valid_i;
   logic        op_ready_o;
   logic [3:0]  op_class_i;
   logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
   logic [5:0]  funct_i;
   logic [31:0] imm_i;
   logic [25:0] target_i;
   logic        addr_load_i;
   logic [31:0] addr_base_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_addr_o;
   logic        err_o;

   instr_encoder dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .op_valid_i    (op_valid_i),
      .op_ready_o    (op_ready_o),
      .op_class_i    (op_class_i),
      .rs_i          (rs_i),
      .rt_i          (rt_i),
      .rd_i          (rd_i),
      .shamt_i       (shamt_i),
      .funct_i       (funct_i),
      .imm_i         (imm_i),
      .target_i      (target_i),
      .addr_load_i   (addr_load_i),
      .addr_base_i   (addr_base_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .instr_addr_o  (instr_addr_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] w;
      logic [31:0] a;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad   = 0;
   int          err_seen = 0;
   logic [31:0] exp_addr = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      exp_t e;
      e.w = w;
      e.a = exp_addr;
      sb_q.push_back(e);
      exp_addr = exp_addr + 32'd4;
   endtask

   // Monitor: compare every transferred word against the scoreboard head.
   always @(negedge clk_i) begin
      if (err_o === 1'b1) err_seen++;
      if (rst_i === 1'b0 && instr_valid_o === 1'b1 && instr_ready_i === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got 0x%08h at 0x%08h, want no word", instr_o, instr_addr_o);
         end else begin
            mon_e = sb_q.pop_front();
            check("word", instr_o, mon_e.w);
            check("addr", instr_addr_o, mon_e.a);
         end
      end
   end

   // Entered and left just after a rising edge.
   task automatic issue(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [31:0] imm, input logic [25:0] tgt,
                        input int nw, input logic [31:0] w0, input logic [31:0] w1);
      bit acc = 1'b0;
      op_class_i = cls; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = sh;
      funct_i = fn; imm_i = imm; target_i = tgt;
      op_valid_i = 1'b1;
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk_i);
         if (op_ready_o === 1'b1) begin
            acc = 1'b1;
            if (nw > 0) push_word(w0);
            if (nw > 1) push_word(w1);
         end
         @(posedge clk_i); #1;
      end
      op_valid_i = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: op_ready_o=%0b want 1 within 20 cycles", op_ready_o);
      end
   endtask

   task automatic drain();
      bit idle = 1'b0;
      for (int n = 0; n < 50 && !idle; n++) begin
         @(negedge clk_i);
         if (instr_valid_o === 1'b0) idle = 1'b1;
      end
      @(posedge clk_i); #1;
      if (!idle) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: instr_valid_o=%0b want 0 within 50 cycles", instr_valid_o);
      end
   endtask

   task automatic load_addr(input logic [31:0] base);
      addr_load_i = 1'b1;
      addr_base_i = base;
      @(posedge clk_i); #1;
      addr_load_i = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] saved_addr;
   int          err_base;

   initial begin : stim
      rst_i = 1'b1; op_valid_i = 1'b0; op_class_i = 4'd0;
      rs_i = 5'd0; rt_i = 5'd0; rd_i = 5'd0; shamt_i = 5'd0; funct_i = 6'd0;
      imm_i = 32'd0; target_i = 26'd0; addr_load_i = 1'b0; addr_base_i = 32'd0;
      instr_ready_i = 1'b1;

      repeat (2) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_instr", instr_o, 32'd0);
      check("rst_addr",  instr_addr_o, 32'd0);
      check("rst_err",   32'(err_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_ready", 32'(op_ready_o), 32'd1);
      @(posedge clk_i); #1;

      // ADDI at base 0x100, valid one cycle after accept
      load_addr(32'h0000_0100);
      exp_addr = 32'h0000_0100;
      issue(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005, 26'd0, 1, 32'h2022_0005, 32'd0);
      @(negedge clk_i);
      check("addi_latency_valid", 32'(instr_valid_o), 32'd1);
      @(posedge clk_i); #1;

      // back-to-back single-word encodings
      issue(4'd0,  5'd1,  5'd2,  5'd3, 5'd0, 6'h20, 32'd0,        26'd0, 1, 32'h0022_1820, 32'd0);
      issue(4'd11, 5'd31, 5'd7,  5'd9, 5'd3, 6'h3F, 32'd0,        26'd0, 1, 32'h03E0_0008, 32'd0);
      issue(4'd2,  5'd1,  5'd2,  5'd0, 5'd0, 6'd0,  32'h0000_0001, 26'd0, 1, 32'h2C22_0001, 32'd0);
      issue(4'd3,  5'd4,  5'd5,  5'd0, 5'd0, 6'd0,  32'h0000_FFFF, 26'd0, 1, 32'h1085_FFFF, 32'd0);
      issue(4'd4,  5'd5,  5'd6,  5'd0, 5'd0, 6'd0,  32'h0000_ABCD, 26'd0, 1, 32'h3C06_ABCD, 32'd0);
      issue(4'd5,  5'd1,  5'd2,  5'd0, 5'd0, 6'd0,  32'hFFFF_F0F0, 26'd0, 1, 32'h3422_F0F0, 32'd0);
      issue(4'd6,  5'd1,  5'd2,  5'd0, 5'd0, 6'd0,  32'h0000_0003, 26'd0, 1, 32'h1422_0003, 32'd0);
      issue(4'd7,  5'd29, 5'd2,  5'd0, 5'd0, 6'd0,  32'h0000_0008, 26'd0, 1, 32'h8FA2_0008, 32'd0);
      issue(4'd8,  5'd29, 5'd31, 5'd0, 5'd0, 6'd0,  32'h0000_0004, 26'd0, 1, 32'hAFBF_0004, 32'd0);
      issue(4'd9,  5'd3,  5'd7,  5'd0, 5'd0, 6'd0,  32'h0000_0010, 26'd0, 1, 32'h1860_0010, 32'd0);
      issue(4'd10, 5'd3,  5'd7,  5'd0, 5'd0, 6'd0,  32'h0000_0010, 26'd0, 1, 32'h1C60_0010, 32'd0);
      issue(4'd12, 5'd0,  5'd0,  5'd0, 5'd0, 6'd0,  32'd0, 26'h3FF_FFFF, 1, 32'h0BFF_FFFF, 32'd0);

      // two-word LI, ready low while the ORI is pending
      issue(4'd14, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678, 26'd0, 2, 32'h3C08_1234, 32'h3508_5678);
      @(negedge clk_i);
      check("li_pend_ready", 32'(op_ready_o), 32'd0);
      @(posedge clk_i); #1;
      issue(4'd14, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h0000_BEEF, 26'd0, 1, 32'h3408_BEEF, 32'd0);
      issue(4'd14, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'hABCD_0000, 26'd0, 1, 32'h3C08_ABCD, 32'd0);
      @(negedge clk_i);
      check("li_single_ready", 32'(op_ready_o), 32'd1);
      @(posedge clk_i); #1;

      // JAL held for 5 cycles by a stalled writer
      drain();
      instr_ready_i = 1'b0;
      saved_addr = exp_addr;
      issue(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 26'h000_0010, 1, 32'h0C00_0010, 32'd0);
      op_class_i = 4'd1; rs_i = 5'd1; rt_i = 5'd2; imm_i = 32'h0000_0005;
      op_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("stall_valid", 32'(instr_valid_o), 32'd1);
         check("stall_word",  instr_o, 32'h0C00_0010);
         check("stall_addr",  instr_addr_o, saved_addr);
         check("stall_ready", 32'(op_ready_o), 32'd0);
         @(posedge clk_i); #1;
      end
      instr_ready_i = 1'b1;
      issue(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005, 26'd0, 1, 32'h2022_0005, 32'd0);

      // addr_load coinciding with an accept is ignored
      drain();
      addr_load_i = 1'b1;
      addr_base_i = 32'h0000_5000;
      issue(4'd5, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 32'h0000_0042, 26'd0, 1, 32'h3403_0042, 32'd0);
      addr_load_i = 1'b0;

      // wrap from 0xFFFFFFFC; low base bits are dropped
      drain();
      load_addr(32'hFFFF_FFFD);
      exp_addr = 32'hFFFF_FFFC;
      issue(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005, 26'd0, 1, 32'h2022_0005, 32'd0);
      issue(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_F0F0, 26'd0, 1, 32'h3422_F0F0, 32'd0);

      // reserved class: err pulse, no word, no address step
      drain();
      err_base = err_seen;
      issue(4'd15, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 32'h1234_5678, 26'd0, 0, 32'd0, 32'd0);
      @(negedge clk_i);
      check("rsvd_err_hi",  32'(err_o), 32'd1);
      check("rsvd_novalid", 32'(instr_valid_o), 32'd0);
      @(negedge clk_i);
      check("rsvd_err_lo",  32'(err_o), 32'd0);
      @(posedge clk_i); #1;
      issue(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005, 26'd0, 1, 32'h2022_0005, 32'd0);
      drain();
      check("rsvd_err_count", 32'(err_seen - err_base), 32'd1);

      // reset while the ORI half of an LI is pending
      instr_ready_i = 1'b0;
      issue(4'd14, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678, 26'd0, 0, 32'd0, 32'd0);
      @(negedge clk_i);
      check("rst_pend_ready", 32'(op_ready_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      instr_ready_i = 1'b1;
      addr_load_i = 1'b1;
      addr_base_i = 32'h0000_8000;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      addr_load_i = 1'b0;
      exp_addr = 32'h0;
      @(negedge clk_i);
      check("rst_pend_valid", 32'(instr_valid_o), 32'd0);
      check("rst_pend_addr",  instr_addr_o, 32'd0);
      check("rst_pend_instr", instr_o, 32'd0);
      check("rst_pend_ready1", 32'(op_ready_o), 32'd1);
      repeat (4) @(negedge clk_i);
      @(posedge clk_i); #1;
      issue(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005, 26'd0, 1, 32'h2022_0005, 32'd0);

      drain();
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these ports:
- op_valid_i  in  1  operation request valid
- op_ready_o  out  1  encoder can accept the request
- op_class_i  in  4  operation class: R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6, LW=7, SW=8, BLEZ=9, BGTZ=10, JR=11, J=12, JAL=13, LI=14, 15 reserved
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register and shift fields
- funct_i  in  6  R-type function field
- imm_i  in  32  immediate; bits [15:0] used except for LI
- target_i  in  26  jump target field
- addr_load_i  in  1  load the write-address counter
- addr_base_i  in  32  new counter value
- instr_valid_o  out  1  instruction word valid
- instr_ready_i  in  1  instruction-memory writer accepts the word
- instr_o  out  32  encoded MIPS word
- instr_addr_o  out  32  byte address for instr_o
- err_o  out  1  one-cycle pulse when a reserved class is accepted

Function
REQ-003 Request handshake: a request SHALL be accepted on a cycle where op_valid_i and op_ready_o are both 1.
REQ-004 Output handshake: a word SHALL be transferred on a cycle where instr_valid_o and instr_ready_i are both 1.
REQ-005 Encodings [31:26|25:21|20:16|15:11|10:6|5:0]:
- R_TYPE SHALL be {000000,rs,rt,rd,shamt,funct}.
- JR SHALL be {000000,rs,0,0,0,001000}.
- I-type SHALL be {op,rs,rt,imm[15:0]} with these op values: ADDI 001000, SLTIU 001011, BEQ 000100, BNE 000101, ORI 001101, LW 100011, SW 101011.
- LUI SHALL use op 001111 with rs=0.
- BLEZ (000110) and BGTZ (000111) SHALL force rt=0.
- J SHALL be {000010,target} and JAL SHALL be {000011,target}.
REQ-006 LI expansion:
- if imm[31:16]==0, the block SHALL emit only ORI rt,$0,imm[15:0];
- else if imm[15:0]==0, it SHALL emit only LUI rt,imm[31:16];
- otherwise it SHALL emit LUI rt,imm[31:16] followed on the next output slot by ORI rt,rt,imm[15:0].
REQ-007 A reserved class (15) SHALL be accepted, SHALL emit no word, and SHALL pulse err_o for 1 cycle on the cycle after acceptance.
REQ-008 FSM states SHALL be EMPTY, FULL and FULL_PEND (the LUI of a two-word LI is held and the ORI is pending). Transitions:
- EMPTY to FULL on a non-expanding accept.
- EMPTY to FULL_PEND on a two-word LI accept.
- FULL to EMPTY on a transfer with no new accept.
- FULL to FULL or FULL_PEND on a transfer combined with a simultaneous accept.
- FULL_PEND to FULL on a transfer, with the ORI loaded into the output register.
REQ-009 op_ready_o SHALL be 1 in EMPTY, SHALL equal instr_ready_i in FULL, and SHALL be 0 in FULL_PEND.
REQ-010 Latency SHALL be 1 cycle from accept to instr_valid_o; throughput SHALL be 1 word per cycle.
REQ-011 While instr_valid_o=1 and instr_ready_i=0, instr_o and instr_addr_o SHALL hold stable.
REQ-012 instr_addr_o SHALL increment by 4 after each transfer and SHALL wrap from 0xFFFFFFFC to 0x00000000.
REQ-013 addr_load_i SHALL take effect only in EMPTY with no accept in the same cycle; otherwise it SHALL be ignored. A load in EMPTY SHALL set the counter to {addr_base_i[31:2],2'b00}.
REQ-014 A reserved-class accept SHALL NOT advance the address counter.

Reset
REQ-015 On rst_i=1 at a clock edge, the block SHALL go to state EMPTY, discard any pending LI second word, and set instr_valid_o=0, instr_o=0, instr_addr_o=0, err_o=0; op_ready_o SHALL be 1 from the following cycle.
REQ-016 Reset SHALL override any handshake or addr_load_i in the same cycle.

Structure
REQ-017 The op-class values, the 6-bit opcode constants, the JR funct constant and the FSM state type SHALL live in a shared package, mips_pkg.
REQ-018 Single-word field packing SHALL be a combinational sub-module, instr_field_pack (inputs: class, fields, LI-half select; output: 32-bit word). The FSM, output register and counter SHALL stay in instr_encoder.

Verification
REQ-019 A bench SHALL cover these directed scenarios:
- ADDI rs=1 rt=2 imm=0x0005 at base 0x100 -> instr_o=0x20220005, addr 0x100, one cycle after accept.
- LI rt=8 imm=0x12345678 -> 0x3C081234 at A, then 0x35085678 at A+4; op_ready_o=0 while in FULL_PEND.
- LI rt=8 imm=0x0000BEEF -> single 0x3408BEEF; LI imm=0xABCD0000 -> single 0x3C08ABCD.
- instr_ready_i held 0 for 5 cycles during JAL target=0x0000010 -> 0x0C000010 stable and no new accept; address advances once on release.
- Counter loaded to 0xFFFFFFFC, then two words -> addresses 0xFFFFFFFC then 0x00000000.
- rst_i asserted in FULL_PEND mid-LI -> next cycle instr_valid_o=0, address 0, ORI never emitted; class 15 -> err_o pulse, no word, no address change.
